// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer and load-use/branch/jump hazard controller for the 5-stage pipeline.
// Optional hazard statistics counters are enabled by defining HAZ_STATS_EN.
module pipeline_sequencer #(
  parameter int NB_REG       = 5,
  parameter int NB_COUNT     = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_run,
  input  logic                i_step,
  input  logic                i_clear,
  input  logic [NB_REG-1:0]   i_id_rs,
  input  logic [NB_REG-1:0]   i_id_rt,
  input  logic                i_id_uses_rt,
  input  logic                i_id_jump,
  input  logic                i_id_halt,
  input  logic [NB_REG-1:0]   i_ex_rt,
  input  logic                i_ex_mem_read,
  input  logic                i_ex_branch_taken,
  output logic                o_pipe_enable,
  output logic                o_pc_write,
  output logic                o_if_id_write,
  output logic                o_id_ex_bubble,
  output logic                o_if_id_flush,
  output logic                o_id_ex_flush,
  output logic                o_halted,
`ifdef HAZ_STATS_EN
  output logic [NB_COUNT-1:0] o_stall_count,
  output logic [NB_COUNT-1:0] o_flush_count,
`endif
  output logic [NB_COUNT-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            drain_q, drain_d;
  logic [NB_COUNT-1:0]   cycle_q, cycle_d;
  logic                  clear_cnt;
  logic                  hz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    clear_cnt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_run)       state_d = S_RUN;
        else if (i_step) state_d = S_STEP;
      end
      S_RUN: begin
        if (i_id_halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (!i_run) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (i_id_halt) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q == 4'd0) state_d = S_HALTED;
        else                 drain_d = drain_q - 4'd1;
      end
      S_HALTED: begin
        if (i_clear) begin
          state_d   = S_IDLE;
          clear_cnt = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rt==0 is the hardwired zero register, so a load into it never creates a hazard.
  assign hz = i_ex_mem_read && (i_ex_rt != '0) &&
              ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

  always_comb begin
    o_pipe_enable  = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_halted       = 1'b0;
    case (state_q)
      S_RUN, S_STEP: begin
        o_pipe_enable = 1'b1;
        if (i_ex_branch_taken) begin
          o_if_id_flush = 1'b1;
          o_id_ex_flush = 1'b1;
          o_pc_write    = 1'b1;
        end else if (hz) begin
          o_if_id_write  = 1'b0;
          o_id_ex_bubble = 1'b1;
        end else if (i_id_jump) begin
          o_if_id_flush = 1'b1;
          o_pc_write    = 1'b1;
        end else begin
          o_pc_write = 1'b1;
        end
      end
      // Instructions younger than HALT are squashed while older ones retire.
      S_DRAIN: begin
        o_pipe_enable = 1'b1;
        o_if_id_flush = 1'b1;
      end
      S_HALTED: o_halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cycle_d = cycle_q;
    if (clear_cnt)          cycle_d = '0;
    else if (o_pipe_enable) cycle_d = cycle_q + NB_COUNT'(1);
  end

  assign o_cycle_count = cycle_q;

`ifdef HAZ_STATS_EN
  logic [NB_COUNT-1:0] stall_q, stall_d;
  logic [NB_COUNT-1:0] flush_q, flush_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clear_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (o_id_ex_bubble)                        stall_d = stall_q + NB_COUNT'(1);
      if (o_if_id_flush && (state_q != S_DRAIN)) flush_d = flush_q + NB_COUNT'(1);
    end
  end

  assign o_stall_count = stall_q;
  assign o_flush_count = flush_q;
`endif

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central run/step/halt sequencer and hazard controller for the 5-stage MIPS pipeline. It sits beside the decode-stage control unit and consumes its decoded mem_read, branch and jump flags plus register indices. It drives the pipeline-register enables, PC write, bubble insertion and flushes. It also gives the debug unit continuous-run, single-step and halt-drain control, with a cycle counter.

Parameters:
NB_REG, 5, register index width
NB_COUNT, 32, cycle/statistics counter width
DRAIN_CYCLES, 4, cycles granted after HALT decode so older instructions reach WB (range 1..15)

Ports:
i_clk  in  1  system clock, all state on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_run  in  1  level: continuous run request from debug unit
i_step  in  1  one-cycle pulse: advance pipeline one clock (honoured only in IDLE)
i_clear  in  1  pulse: leave HALTED, zero counters
i_id_rs  in  NB_REG  rs of instruction in ID
i_id_rt  in  NB_REG  rt of instruction in ID
i_id_uses_rt  in  1  ID instruction reads rt as a source
i_id_jump  in  1  jump decoded in ID
i_id_halt  in  1  HALT opcode decoded in ID
i_ex_rt  in  NB_REG  destination rt of instruction in EX
i_ex_mem_read  in  1  EX instruction is a load
i_ex_branch_taken  in  1  branch resolved taken in EX
o_pipe_enable  out  1  global enable for all pipeline registers
o_pc_write  out  1  PC update enable
o_if_id_write  out  1  IF/ID register write enable
o_id_ex_bubble  out  1  zero control fields entering ID/EX
o_if_id_flush  out  1  clear IF/ID
o_id_ex_flush  out  1  clear ID/EX
o_halted  out  1  sequencer in HALTED
o_cycle_count  out  NB_COUNT  enabled cycles since reset/clear

Behaviour:
- Reset (i_rst_n=0, async): state=IDLE; drain counter=0; o_cycle_count=0. All outputs 0 except o_if_id_write=1.
- States, registered: IDLE, RUN, STEP, DRAIN, HALTED. Outputs are combinational from state and inputs in the same cycle.
- IDLE: o_pipe_enable=0. i_run=1 -> RUN. Else i_step=1 -> STEP. i_run has priority over i_step.
- STEP: o_pipe_enable=1 for exactly one cycle. Next state is IDLE, or DRAIN if i_id_halt=1 that cycle.
- RUN: o_pipe_enable=1. i_id_halt=1 -> DRAIN. Else i_run=0 -> IDLE.
- DRAIN: o_pipe_enable=1, o_pc_write=0, o_if_id_flush=1. The counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; at 0 -> HALTED. DRAIN ignores i_run, i_step and i_clear. It runs freely in both run and step modes.
- HALTED: o_pipe_enable=0, o_halted=1. i_clear=1 -> IDLE, o_cycle_count=0 the next cycle. i_run and i_step are ignored.
- Load-use hazard:
  - hz = i_ex_mem_read & (i_ex_rt!=0) & ((i_ex_rt==i_id_rs) | (i_id_uses_rt & i_ex_rt==i_id_rt)).
  - Evaluated only when o_pipe_enable=1 and state!=DRAIN.
  - On hz: o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1 (one cycle; the hazard clears because EX then holds a bubble).
- Branch taken (pipe enabled): o_if_id_flush=1, o_id_ex_flush=1, o_pc_write=1. This overrides hz, and no bubble is asserted.
- Jump in ID (pipe enabled, no branch taken): o_if_id_flush=1, o_pc_write=1. hz still stalls: o_pc_write=0, flush suppressed.
- Defaults when pipe enabled and no event: o_pc_write=1, o_if_id_write=1, bubble and flushes 0. When pipe disabled, all of o_pc_write, o_id_ex_bubble and the flushes are 0.
- o_cycle_count increments on every edge with o_pipe_enable=1 and wraps at 2^NB_COUNT. A stall cycle counts, and a stall consumes a step.
- In step mode a hazard needs two steps to advance the instruction in ID.

Optional Feature:
HAZ_STATS_EN:
- Defined: adds outputs o_stall_count and o_flush_count (NB_COUNT each, wrapping).
  - o_stall_count increments per cycle with o_id_ex_bubble=1.
  - o_flush_count increments per cycle with o_if_id_flush=1 outside DRAIN.
  - Both counters are zeroed by reset and i_clear.
- Undefined: these ports and counters are absent.

Test Plan:
- Reset, then i_run=1 for 10 cycles, no hazards -> o_pipe_enable=1, o_pc_write=1 every cycle, o_cycle_count=10.
- RUN with i_ex_mem_read=1, i_ex_rt=5, i_id_rs=5 for one cycle -> o_pc_write=0, o_if_id_write=0, o_id_ex_bubble=1 that cycle. Repeat with i_ex_rt=0 -> no stall.
- RUN with i_ex_branch_taken=1 while the hazard condition is also true -> o_if_id_flush=1, o_id_ex_flush=1, o_id_ex_bubble=0, o_pc_write=1.
- IDLE, three i_step pulses separated by idle cycles -> o_pipe_enable high exactly 3 cycles, o_cycle_count=3. i_step while i_run=1 -> enters RUN, not STEP.
- RUN, i_id_halt=1 with DRAIN_CYCLES=4 -> 4 cycles of o_pc_write=0, o_if_id_flush=1, then o_halted=1. i_run is ignored. i_clear -> IDLE, o_cycle_count=0.
- Assert i_rst_n=0 mid-DRAIN, asynchronously between edges -> state IDLE immediately, o_halted=0, o_cycle_count=0, o_pipe_enable=0.
